// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM states and RV32I load/store funct3 codes for the data memory responder.
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  function automatic logic legal_f3(input logic we, input logic [2:0] f3);
    return we ? (f3 == SB || f3 == SH || f3 == SW)
              : (f3 == LB || f3 == LH || f3 == LW || f3 == LBU || f3 == LHU);
  endfunction
endpackage

// File: rtl/load_ext.sv
// load_ext: selects the addressed byte/halfword lane of a word and sign/zero-extends it.
module load_ext
  import dmem_pkg::*;
(
  input  logic [31:0] rdword,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdword[{addr, 3'b000} +: 8];
  assign h = addr[1] ? rdword[31:16] : rdword[15:0];
  assign data = funct3 == LB  ? {{24{b[7]}}, b} :
                funct3 == LBU ? {24'b0, b} :
                funct3 == LH  ? {{16{h[15]}}, h} :
                funct3 == LHU ? {16'b0, h} : rdword;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised data memory answering RV32I loads/stores after a fixed latency.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT0 = 4'(LATENCY > 0 ? LATENCY - 1 : 0);
  state_t state, nxt;
  logic [3:0] cnt;
  logic l_we, c_we, idle, enter, err;
  logic [2:0] l_f3, c_f3;
  logic [31:0] l_addr, l_wdata, c_addr, c_wdata, rdword, ldata, wd;
  logic [3:0] be;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH];
  assign idle = state == IDLE;
  assign req_ready = idle;
  assign resp_valid = state == RESP;
  // with zero latency the access happens on the accept edge, so use the live request
  assign c_we    = idle ? req_we     : l_we;
  assign c_f3    = idle ? req_funct3 : l_f3;
  assign c_addr  = idle ? req_addr   : l_addr;
  assign c_wdata = idle ? req_wdata  : l_wdata;
  always_comb begin
    nxt = state;
    if (idle && req_valid) nxt = LATENCY == 0 ? RESP : WAIT;
    else if (state == WAIT && cnt == 4'd0) nxt = RESP;
    else if (state == RESP && resp_ready) nxt = IDLE;
  end
  assign enter = nxt == RESP && state != RESP;
  assign err = !legal_f3(c_we, c_f3) || c_addr[31:2] >= 30'(DEPTH) ||
               (c_f3[1:0] == 2'b01 && c_addr[0]) || (c_f3[1:0] == 2'b10 && c_addr[1:0] != 2'b00);
  assign idx = c_addr[AW+1:2];
  assign rdword = mem[idx];
  assign be = c_f3[1:0] == 2'b00 ? 4'b0001 << c_addr[1:0] :
              c_f3[1:0] == 2'b01 ? (c_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wd = c_f3[1:0] == 2'b00 ? {4{c_wdata[7:0]}} :
              c_f3[1:0] == 2'b01 ? {2{c_wdata[15:0]}} : c_wdata;
  load_ext u_load_ext (.rdword(rdword), .addr(c_addr[1:0]), .funct3(c_f3), .data(ldata));
  // storage is not reset; a write is also blocked while reset is held
  always_ff @(posedge clk)
    if (enter && reset && c_we && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      resp_rdata <= 32'd0;
      resp_err <= 1'b0;
      l_we <= 1'b0;
      l_f3 <= 3'd0;
      l_addr <= 32'd0;
      l_wdata <= 32'd0;
    end else begin
      state <= nxt;
      if (idle && req_valid) begin
        cnt <= CNT0;
        l_we <= req_we;
        l_f3 <= req_funct3;
        l_addr <= req_addr;
        l_wdata <= req_wdata;
      end else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (enter) begin
        resp_rdata <= (err || c_we) ? 32'd0 : ldata;
        resp_err <= err;
      end
    end
endmodule
